edge_pe_bank_arbiter: RTL and testbench

Arbitrates the shared packet SRAM bank between up to NUM_REQ Edge PE burst-read requesters. Round-robin grant; sequences one burst of consecutive reads per grant, stalling while the bank is busy. Routes returned data to the granted PE and signals completion. Sits between the Edge PE array and the packet SRAM read port, beside the packet controller.

---
 rtl/edge_pe_bank_arbiter_pkg.sv | 27 ++
 rtl/edge_pe_bank_arbiter_rr_pick.sv | 33 +++
 rtl/edge_pe_bank_arbiter.sv | 122 ++++++++++++
 tb/tb_edge_pe_bank_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/edge_pe_bank_arbiter_pkg.sv
// Shared types and default sizing for the Edge PE packet-SRAM bank arbiter.
// Used by edge_pe_bank_arbiter and its testbench-facing defaults.
package edge_pe_bank_arbiter_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_ADDR_W  = 12;
  localparam int ARB_BURST_W = 4;
  localparam int ARB_DATA_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } arb_state_t;

  // Burst captured at grant time; the requester may change its inputs afterwards.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0]  addr;
    logic [ARB_BURST_W-1:0] len;
  } arb_req_t;

  // A zero-length request still moves one beat.
  function automatic logic [ARB_BURST_W-1:0] eff_len(input logic [ARB_BURST_W-1:0] len);
    return (len == '0) ? ARB_BURST_W'(1) : len;
  endfunction

endpackage

// File: rtl/edge_pe_bank_arbiter_rr_pick.sv
// Circular priority encoder: first set req bit at or after ptr, wrapping.
// Purely combinational; produces one-hot, index and a valid flag.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] j;
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      j = sum[IDX_W-1:0];
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/edge_pe_bank_arbiter.sv
// Round-robin arbiter sequencing Edge PE burst reads onto the packet SRAM bank.
// Define EDGE_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins.
module edge_pe_bank_arbiter
  import edge_pe_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int BURST_W = ARB_BURST_W,
  parameter int DATA_W  = ARB_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  input  logic                       flush,
  input  logic                       bank_busy,
  output logic                       sram_rd_en,
  output logic [ADDR_W-1:0]          sram_addr,
  input  logic [DATA_W-1:0]          sram_rdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  arb_req_t            cur;
  logic [IDX_W-1:0]    cur_id;
  logic [BURST_W-1:0]  beat_cnt;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_ptr;

`ifdef EDGE_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  // Pointer advances only on a completed burst; a flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == DRAIN && !flush) begin
      rr_ptr <= (cur_id == IDX_W'(NUM_REQ-1)) ? '0 : cur_id + 1'b1;
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign sram_rd_en = (state == BURST) && !bank_busy;
  assign sram_addr  = (state == BURST) ? cur.addr + ADDR_W'(beat_cnt) : '0;
  assign rsp_data   = sram_rdata;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state here uses <= so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      cur_id    <= '0;
      beat_cnt  <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      done      <= '0;
    end else begin
      // Read data returns one cycle after the strobe; a flush drops it.
      rsp_valid <= (sram_rd_en && !flush) ? gnt : '0;
      done      <= '0;
      if (flush) begin
        state    <= IDLE;
        gnt      <= '0;
        beat_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              cur_id   <= pick_idx;
              cur.addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
              cur.len  <= eff_len(req_len[pick_idx*BURST_W +: BURST_W]);
              beat_cnt <= '0;
              gnt      <= pick_onehot;
              state    <= BURST;
            end
          end
          BURST: begin
            if (sram_rd_en) begin
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == cur.len - 1'b1) begin
                state <= DRAIN;
                done  <= gnt;
              end
            end
          end
          DRAIN: begin
            state <= IDLE;
            gnt   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_pe_bank_arbiter.sv
// Directed self-checking bench for edge_pe_bank_arbiter; expectations are hand-derived.
// Expected grant orders switch when EDGE_ARB_FIXED_PRIO_EN is defined.
module tb_edge_pe_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] req_addr;
  logic [15:0] req_len;
  logic        flush;
  logic        bank_busy;
  logic        sram_rd_en;
  logic [11:0] sram_addr;
  logic [63:0] sram_rdata;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [3:0]  done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  edge_pe_bank_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .flush      (flush),
    .bank_busy  (bank_busy),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic rd,
                            input logic chk_a, input logic [11:0] a, input logic [3:0] rv,
                            input logic [3:0] d, input logic b);
    check($sformatf("%s.gnt", tag), 64'(gnt), 64'(g));
    check($sformatf("%s.rd_en", tag), 64'(sram_rd_en), 64'(rd));
    if (chk_a) check($sformatf("%s.addr", tag), 64'(sram_addr), 64'(a));
    check($sformatf("%s.rsp_valid", tag), 64'(rsp_valid), 64'(rv));
    check($sformatf("%s.done", tag), 64'(done), 64'(d));
    check($sformatf("%s.busy", tag), 64'(busy), 64'(b));
  endtask

  task automatic set_pe(input int i, input logic [11:0] a, input logic [3:0] l);
    req_addr[i*12 +: 12] = a;
    req_len[i*4 +: 4]    = l;
  endtask

  initial begin
    logic [3:0]  eg;
    logic [11:0] eb;
    int          ph;
    int          nb;

    reset = 1'b1; req = '0; req_addr = '0; req_len = '0;
    flush = 1'b0; bank_busy = 1'b0; sram_rdata = '0;

    // Reset state
    @(negedge clk); #1;
    expect_out("rst", 4'b0000, 1'b0, 1'b1, 12'h000, 4'b0000, 4'b0000, 1'b0);

    // PE0 and PE2 held from reset, len 2: alternate with a single idle cycle between
    set_pe(0, 12'h200, 4'd2);
    set_pe(2, 12'h300, 4'd2);
    req = 4'b0101;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      ph = c % 4;
      nb = c / 4;
`ifdef EDGE_ARB_FIXED_PRIO_EN
      eg = (ph == 0) ? 4'b0000 : 4'b0001;
`else
      eg = (ph == 0) ? 4'b0000 : ((nb % 2 == 0) ? 4'b0001 : 4'b0100);
`endif
      eb = (eg == 4'b0001) ? 12'h200 : 12'h300;
      expect_out($sformatf("rr.c%0d", c), eg, (ph == 1 || ph == 2),
                 (ph == 1 || ph == 2), eb + 12'(ph - 1),
                 (ph >= 2) ? eg : 4'b0000, (ph == 3) ? eg : 4'b0000, ph != 0);
      @(negedge clk);
    end
    req = '0;

    // PE1 addr 0x010 len 4, bank idle
    @(negedge clk); set_pe(1, 12'h010, 4'd4); req = 4'b0010; #1;
    expect_out("t1.req", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      expect_out($sformatf("t1.b%0d", b), 4'b0010, 1'b1, 1'b1, 12'(12'h010 + b),
                 (b == 0) ? 4'b0000 : 4'b0010, 4'b0000, 1'b1);
    end
    @(negedge clk); req = '0; sram_rdata = 64'h0123_4567_89AB_CDEF; #1;
    expect_out("t1.drain", 4'b0010, 1'b0, 1'b0, 12'h000, 4'b0010, 4'b0010, 1'b1);
    check("t1.rsp_data", rsp_data, 64'h0123_4567_89AB_CDEF);
    @(negedge clk); #1;
    expect_out("t1.idle", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);

    // PE3 addr 0x100 len 3, bank stalls two cycles after the first beat
    @(negedge clk); set_pe(3, 12'h100, 4'd3); req = 4'b1000; #1;
    @(negedge clk); #1;
    expect_out("st.t1", 4'b1000, 1'b1, 1'b1, 12'h100, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); bank_busy = 1'b1; #1;
    expect_out("st.t2", 4'b1000, 1'b0, 1'b1, 12'h101, 4'b1000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    expect_out("st.t3", 4'b1000, 1'b0, 1'b1, 12'h101, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); bank_busy = 1'b0; #1;
    expect_out("st.t4", 4'b1000, 1'b1, 1'b1, 12'h101, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    expect_out("st.t5", 4'b1000, 1'b1, 1'b1, 12'h102, 4'b1000, 4'b0000, 1'b1);
    @(negedge clk); req = '0; #1;
    expect_out("st.t6", 4'b1000, 1'b0, 1'b0, 12'h000, 4'b1000, 4'b1000, 1'b1);
    @(negedge clk); #1;
    expect_out("st.t7", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);

    // PE0 addr 0xFFE len 3 wraps the address space
    @(negedge clk); set_pe(0, 12'hFFE, 4'd3); req = 4'b0001; #1;
    @(negedge clk); #1;
    expect_out("wr.t1", 4'b0001, 1'b1, 1'b1, 12'hFFE, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    expect_out("wr.t2", 4'b0001, 1'b1, 1'b1, 12'hFFF, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk); #1;
    expect_out("wr.t3", 4'b0001, 1'b1, 1'b1, 12'h000, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk); req = '0; #1;
    expect_out("wr.t4", 4'b0001, 1'b0, 1'b0, 12'h000, 4'b0001, 4'b0001, 1'b1);

    // PE2 len 8 flushed during beat 2; pointer must not move
    @(negedge clk); set_pe(2, 12'h040, 4'd8); req = 4'b0100; #1;
    @(negedge clk); #1;
    expect_out("fl.t1", 4'b0100, 1'b1, 1'b1, 12'h040, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); flush = 1'b1; #1;
    expect_out("fl.t2", 4'b0100, 1'b1, 1'b1, 12'h041, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk); flush = 1'b0; set_pe(0, 12'h080, 4'd1); req = 4'b0101; #1;
    expect_out("fl.t3", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); flush = 1'b1; #1;
`ifdef EDGE_ARB_FIXED_PRIO_EN
    expect_out("fl.t4", 4'b0001, 1'b1, 1'b1, 12'h080, 4'b0000, 4'b0000, 1'b1);
`else
    expect_out("fl.t4", 4'b0100, 1'b1, 1'b1, 12'h040, 4'b0000, 4'b0000, 1'b1);
`endif
    @(negedge clk); #1;
    expect_out("fl.t5", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); flush = 1'b0; req = '0; #1;
    expect_out("fl.t6", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);

    // PE3 len 0 behaves as a single beat
    @(negedge clk); set_pe(3, 12'h555, 4'd0); req = 4'b1000; #1;
    @(negedge clk); #1;
    expect_out("z.t1", 4'b1000, 1'b1, 1'b1, 12'h555, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); req = '0; #1;
    expect_out("z.t2", 4'b1000, 1'b0, 1'b0, 12'h000, 4'b1000, 4'b1000, 1'b1);
    @(negedge clk); #1;
    expect_out("z.t3", 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);

    // All four requesting with len 1: rotation 0,1,2,3 (fixed priority: PE0 each time)
    for (int i = 0; i < 4; i++) set_pe(i, 12'(12'h700 + 16 * i), 4'd1);
    @(negedge clk); req = 4'b1111; #1;
    for (int k = 0; k < 4; k++) begin
`ifdef EDGE_ARB_FIXED_PRIO_EN
      eg = 4'b0001;
      eb = 12'h700;
`else
      eg = 4'(1 << k);
      eb = 12'(12'h700 + 16 * k);
`endif
      @(negedge clk); #1;
      expect_out($sformatf("all.b%0d", k), eg, 1'b1, 1'b1, eb, 4'b0000, 4'b0000, 1'b1);
      @(negedge clk); #1;
      expect_out($sformatf("all.d%0d", k), eg, 1'b0, 1'b0, 12'h000, eg, eg, 1'b1);
      @(negedge clk); if (k == 3) req = '0; #1;
      expect_out($sformatf("all.i%0d", k), 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
